// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per cycle with registered ripple carry
//   clock, reset                  : clock and synchronous active-high reset
//   in_valid/in_ready             : operand handshake (in_a, in_b, in_sub: 0 add, 1 subtract)
//   out_valid/out_ready           : result handshake
//   out_sum                       : {carry_out, sum}
//   out_overflow                  : two's-complement signed overflow of the WIDTH-bit sum
module chunked_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_overflow
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] a, b;
   logic             carry;
   logic [IW-1:0]    idx;
   int               sh;
   logic [CHUNK-1:0] sa, sb, s;
   logic             c, last, accept;
   logic [WIDTH-1:0] mask, ins, lower;
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (state == IDLE) state_n = in_valid ? BUSY : IDLE;
      if (state == BUSY) state_n = last ? DONE : BUSY;
      if (state == DONE) state_n = out_ready ? (in_valid ? BUSY : IDLE) : DONE;
   end
   always_comb begin
      in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
      out_valid = state == DONE;
   end
   // current chunk is selected by shifting, then merged back into the partial sum under a mask
   always_comb begin
      accept = in_valid & in_ready;
      last   = idx == IW'(N - 1);
      sh     = CHUNK * int'(idx);
      sa     = CHUNK'(a >> sh);
      sb     = CHUNK'(b >> sh);
      {c, s} = {1'b0, sa} + {1'b0, sb} + (CHUNK + 1)'(carry);
      mask   = WIDTH'({CHUNK{1'b1}}) << sh;
      ins    = WIDTH'(s) << sh;
      lower  = (out_sum[WIDTH-1:0] & ~mask) | ins;
   end
   always_ff @(posedge clock)
      if (reset) begin
         a            <= '0;
         b            <= '0;
         carry        <= 1'b0;
         idx          <= '0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
      end else if (accept) begin
         a            <= in_a;
         b            <= in_sub ? ~in_b : in_b;
         carry        <= in_sub;
         idx          <= '0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
      end else if (state == BUSY) begin
         out_sum <= {last ? c : out_sum[WIDTH], lower};
         carry   <= c;
         idx     <= last ? '0 : idx + 1'b1;
         if (last) out_overflow <= (a[WIDTH-1] == b[WIDTH-1]) & (lower[WIDTH-1] != a[WIDTH-1]);
      end
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: scoreboard bench for chunked_adder (CHUNK=2 main instance, CHUNK=8 latency instance)
module tb_chunked_adder;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic       in_ready, out_valid, out_overflow;
   logic [8:0] out_sum;
   logic       in_valid8 = 1'b0, in_sub8 = 1'b0, out_ready8 = 1'b1;
   logic [7:0] in_a8 = '0, in_b8 = '0;
   logic       in_ready8, out_valid8, out_overflow8;
   logic [8:0] out_sum8;
   chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow));
   chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_a(in_a8), .in_b(in_b8), .in_sub(in_sub8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_sum(out_sum8), .out_overflow(out_overflow8));
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;
   typedef struct {
      logic [8:0] s;
      logic       o;
      int         acc;
   } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   logic pv = 1'b0;
   int   rise = 0;
   always @(negedge clock) begin : mon
      exp_t e;
      if (out_valid && !pv) rise = cyc;
      pv = out_valid;
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("sum", 32'(out_sum), 32'(e.s));
            chk("overflow", 32'(out_overflow), 32'(e.o));
            chk("latency", rise - e.acc, 32'd4);
         end
      end
   end
   task automatic wait_ready();
      logic ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clock);
         ok = in_ready;
      end
      if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
   endtask
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [8:0] s, input logic o);
      in_a = a;
      in_b = b;
      in_sub = sub;
      in_valid = 1'b1;
      wait_ready();
      @(posedge clock);
      #1;
      q.push_back('{s, o, cyc});
      in_valid = 1'b0;
   endtask
   task automatic drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clock);
      if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
      @(posedge clock);
      #1;
   endtask
   initial begin
      logic seen;
      in_valid = 1'b1;
      in_a = 8'hAA;
      in_b = 8'h55;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_sum", 32'(out_sum), 32'd0);
      chk("reset_overflow", 32'(out_overflow), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid8", 32'(out_valid8), 32'd0);
      @(posedge clock);
      #1;
      send(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
      send(8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0);
      send(8'h80, 8'h01, 1'b1, 9'h17F, 1'b1);
      send(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
      send(8'h00, 8'h00, 1'b1, 9'h100, 1'b0);
      send(8'h07, 8'h05, 1'b1, 9'h102, 1'b0);
      drain();
      out_ready = 1'b0;
      send(8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
      in_a = 8'h10;
      in_b = 8'h20;
      in_sub = 1'b0;
      in_valid = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clock);
         seen = out_valid;
      end
      chk("bp_reach_done", 32'(seen), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_sum", 32'(out_sum), 32'h100);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      q.push_back('{9'h030, 1'b0, cyc});
      in_valid = 1'b0;
      drain();
      in_a = 8'h03;
      in_b = 8'h04;
      in_valid = 1'b1;
      wait_ready();
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         seen = seen | out_valid;
      end
      chk("midreset_dropped", 32'(seen), 32'd0);
      @(posedge clock);
      #1;
      send(8'h10, 8'h20, 1'b0, 9'h030, 1'b0);
      drain();
      in_a8 = 8'h7F;
      in_b8 = 8'h01;
      in_sub8 = 1'b0;
      in_valid8 = 1'b1;
      @(negedge clock);
      chk("c8_in_ready", 32'(in_ready8), 32'd1);
      @(posedge clock);
      #1;
      in_valid8 = 1'b0;
      @(negedge clock);
      chk("c8_busy", 32'(out_valid8), 32'd0);
      @(negedge clock);
      chk("c8_out_valid", 32'(out_valid8), 32'd1);
      chk("c8_out_sum", 32'(out_sum8), 32'h080);
      chk("c8_overflow", 32'(out_overflow8), 32'd1);
      @(posedge clock);
      #1;
      in_a8 = 8'h05;
      in_b8 = 8'h07;
      in_sub8 = 1'b1;
      in_valid8 = 1'b1;
      @(negedge clock);
      chk("c8_in_ready2", 32'(in_ready8), 32'd1);
      @(posedge clock);
      #1;
      in_valid8 = 1'b0;
      @(negedge clock);
      chk("c8_busy2", 32'(out_valid8), 32'd0);
      @(negedge clock);
      chk("c8_out_valid2", 32'(out_valid8), 32'd1);
      chk("c8_out_sum2", 32'(out_sum8), 32'h0FE);
      chk("c8_overflow2", 32'(out_overflow8), 32'd0);
      @(posedge clock);
      #1;
      chk("queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
